mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 47 ++++
 rtl/mem_access_unit_if.sv | 30 +++
 rtl/mem_access_unit_load_ext.sv | 35 +++
 rtl/mem_access_unit.sv | 141 ++++++++++++++
 tb/tb_mem_access_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg : shared MemOp codes, FSM encoding and byte-enable constants
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_NONE    = 4'b0000;

  function automatic logic is_store(mem_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_misaligned(mem_op_e op, logic [1:0] lo);
    case (op)
      OP_LW, OP_SW:         return lo != 2'b00;
      OP_LH, OP_LHU, OP_SH: return lo[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if : word-wide memory bus between access unit and memory
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit_load_ext.sv
// ---------------------------------------------------------------------------
// load_ext : selects byte/halfword lane of a bus word and sign/zero extends
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_ext
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  mem_op_e     mem_op,
  input  logic [1:0]  lane,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    result   = '0;
    case (mem_op)
      OP_LW:   result = word;
      OP_LH:   result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result = {16'h0000, half_sel};
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'h000000, byte_sel};
      default: result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit : MEM-stage load/store unit driving a req/gnt/rvalid bus
// Optional alignment trap enabled by defining MEM_ALIGN_CHECK_EN
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        MemOp,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              exc,
  mem_access_unit_if.master bus
);

  state_e            state_q, state_d;
  mem_op_e           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              exc_q, exc_d;

  logic              misalign;
  logic              in_req;
  logic [31:0]       load_word;
  logic [3:0]        be_calc;
  logic [31:0]       wdata_calc;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_misaligned(mem_op_e'(MemOp), addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  load_ext u_load_ext (
    .word   (bus.bus_rdata),
    .mem_op (op_q),
    .lane   (addr_q[1:0]),
    .result (load_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
    end
  end

  // Misaligned accesses bypass the bus entirely and report straight from IDLE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = mem_op_e'(MemOp);
          addr_d  = addr;
          wdata_d = wdata;
          exc_d   = misalign;
          state_d = misalign ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.bus_gnt) begin
          state_d = is_store(op_q) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.bus_rvalid) begin
          rdata_d = load_word;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    be_calc    = BE_NONE;
    wdata_calc = '0;
    case (op_q)
      OP_SW: begin
        be_calc    = BE_WORD;
        wdata_calc = wdata_q;
      end
      OP_SH: begin
        be_calc    = addr_q[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_calc = {2{wdata_q[15:0]}};
      end
      OP_SB: begin
        be_calc    = BE_BYTE0 << addr_q[1:0];
        wdata_calc = {4{wdata_q[7:0]}};
      end
      default: be_calc = BE_WORD;
    endcase
  end

  // Bus outputs are zero outside REQ so they idle at their reset values.
  assign in_req        = (state_q == ST_REQ);
  assign bus.bus_req   = in_req;
  assign bus.bus_we    = in_req & is_store(op_q);
  assign bus.bus_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.bus_be    = in_req ? be_calc : BE_NONE;
  assign bus.bus_wdata = in_req ? wdata_calc : '0;

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign exc       = rsp_valid & exc_q;
  assign rdata     = (rsp_valid && (is_store(op_q) || exc_q)) ? '0 : rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit : directed self-checking bench for mem_access_unit
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  MemOp;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        busy;
  logic        exc;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit_if #(.ADDR_W(32)) bus_if ();

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .MemOp     (MemOp),
    .addr      (addr),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .busy      (busy),
    .exc       (exc),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction; the grant cycle also carries a junk rvalid for loads.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input int gnt_dly, input logic [31:0] bus_data,
                        input logic [3:0] exp_be, input logic [31:0] exp_bwd,
                        input logic [31:0] exp_rdata, input bit hold_req);
    bit is_st;
    is_st     = (op >= 3'b101);
    req_valid = 1'b1;
    MemOp     = op;
    addr      = a;
    wdata     = wd;
    tick();
    if (hold_req) begin
      MemOp = 3'b111;
      addr  = 32'h0000_00FF;
      wdata = 32'h0000_0077;
    end else begin
      req_valid = 1'b0;
    end
    chk({tag, ".bus_req"}, 32'(bus_if.bus_req), 32'd1);
    chk({tag, ".bus_addr"}, bus_if.bus_addr, {a[31:2], 2'b00});
    chk({tag, ".bus_be"}, 32'(bus_if.bus_be), 32'(exp_be));
    chk({tag, ".bus_we"}, 32'(bus_if.bus_we), 32'(is_st));
    if (is_st) chk({tag, ".bus_wdata"}, bus_if.bus_wdata, exp_bwd);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < gnt_dly; i++) begin
      tick();
      chk({tag, ".hold_req"}, 32'(bus_if.bus_req), 32'd1);
      chk({tag, ".hold_addr"}, bus_if.bus_addr, {a[31:2], 2'b00});
      chk({tag, ".hold_be"}, 32'(bus_if.bus_be), 32'(exp_be));
      if (is_st) chk({tag, ".hold_wdata"}, bus_if.bus_wdata, exp_bwd);
    end
    bus_if.bus_gnt = 1'b1;
    if (!is_st) begin
      bus_if.bus_rvalid = 1'b1;
      bus_if.bus_rdata  = ~bus_data;
    end
    tick();
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    if (!is_st) begin
      chk({tag, ".wait_rsp"}, 32'(rsp_valid), 32'd0);
      chk({tag, ".wait_req"}, 32'(bus_if.bus_req), 32'd0);
      tick();
      bus_if.bus_rvalid = 1'b1;
      bus_if.bus_rdata  = bus_data;
      tick();
      bus_if.bus_rvalid = 1'b0;
      bus_if.bus_rdata  = 32'h0;
    end
    req_valid = 1'b0;
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rdata"}, rdata, exp_rdata);
    chk({tag, ".exc"}, 32'(exc), 32'd0);
    tick();
    chk({tag, ".rsp_once"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset             = 1'b1;
    req_valid         = 1'b0;
    MemOp             = 3'b000;
    addr              = 32'h0;
    wdata             = 32'h0;
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = 32'h0;
    tick();
    tick();
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.rsp", 32'(rsp_valid), 32'd0);
    chk("rst.bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst.bus_be", 32'(bus_if.bus_be), 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.exc", 32'(exc), 32'd0);
    reset = 1'b0;
    tick();

    // Stray bus handshakes while idle must not start anything.
    bus_if.bus_gnt    = 1'b1;
    bus_if.bus_rvalid = 1'b1;
    tick();
    tick();
    chk("idle_noise.busy", 32'(busy), 32'd0);
    chk("idle_noise.rsp", 32'(rsp_valid), 32'd0);
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;

    run_op("lb_13",  3'b011, 32'h13,  32'h0,         1, 32'h80FF1234, 4'b1111, 32'h0,        32'hFFFFFF80, 1'b0);
    run_op("sh_22",  3'b110, 32'h22,  32'h0000ABCD,  3, 32'h0,        4'b1100, 32'hABCDABCD, 32'h0,        1'b0);
    chk("hold_after_store", rdata, 32'hFFFFFF80);
    run_op("lhu_40", 3'b010, 32'h40,  32'h0,         2, 32'h1234F00D, 4'b1111, 32'h0,        32'h0000F00D, 1'b1);
    chk("b2b.idle", 32'(busy), 32'd0);
    run_op("sb_07",  3'b111, 32'h07,  32'h0000005A,  0, 32'h0,        4'b1000, 32'h5A5A5A5A, 32'h0,        1'b0);
    run_op("sw_30",  3'b101, 32'h30,  32'hDEADBEEF,  0, 32'h0,        4'b1111, 32'hDEADBEEF, 32'h0,        1'b0);
    run_op("lh_46",  3'b001, 32'h46,  32'h0,         0, 32'h80017FFF, 4'b1111, 32'h0,        32'hFFFF8001, 1'b0);
    run_op("lbu_11", 3'b100, 32'h11,  32'h0,         0, 32'h80FF1234, 4'b1111, 32'h0,        32'h00000012, 1'b0);
    run_op("lw_50",  3'b000, 32'h50,  32'h0,         1, 32'hCAFEF00D, 4'b1111, 32'h0,        32'hCAFEF00D, 1'b0);

    // Reset while waiting for read data abandons the load.
    req_valid = 1'b1;
    MemOp     = 3'b000;
    addr      = 32'h60;
    tick();
    req_valid      = 1'b0;
    bus_if.bus_gnt = 1'b1;
    tick();
    bus_if.bus_gnt = 1'b0;
    reset          = 1'b1;
    tick();
    reset             = 1'b0;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'h12345678;
    chk("midrst.bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.rsp", 32'(rsp_valid), 32'd0);
    chk("midrst.rdata", rdata, 32'd0);
    chk("midrst.bus_addr", bus_if.bus_addr, 32'd0);
    tick();
    bus_if.bus_rvalid = 1'b0;
    chk("midrst.rsp_after", 32'(rsp_valid), 32'd0);
    chk("midrst.ready", 32'(req_ready), 32'd1);
    chk("midrst.rdata_after", rdata, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
    req_valid = 1'b1;
    MemOp     = 3'b000;
    addr      = 32'h102;
    tick();
    req_valid = 1'b0;
    chk("misal.bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("misal.rsp", 32'(rsp_valid), 32'd1);
    chk("misal.exc", 32'(exc), 32'd1);
    chk("misal.rdata", rdata, 32'd0);
    tick();
    chk("misal.rsp_once", 32'(rsp_valid), 32'd0);
    chk("misal.exc_clr", 32'(exc), 32'd0);
`else
    run_op("lw_102", 3'b000, 32'h102, 32'h0, 0, 32'h11223344, 4'b1111, 32'h0, 32'h11223344, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
